// File: rtl/ec_scalar_mul_ctrl.sv
// ec_scalar_mul_ctrl
// Left-to-right double-and-add sequencer for k*P on y^2 = x^3 + a*x + b over
// GF(p), p <= 61. It drives a single EC point-add/double unit through its
// in_valid/out_valid handshake. It resolves every degenerate case locally:
// the point at infinity, R + (-R), and doubling a point with y = 0.
//
// Optional feature: define ECSM_TIMEOUT_EN to add a per-request watchdog and
// the out_err port.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for in_valid; latches operands on acceptance
// S_SCAN     | doubling step for bit k[idx] (skip / y=0 rule / request)
// S_DBL_REQ  | one-cycle doubling request to the EC unit (P = Q = R)
// S_DBL_WAIT | waiting for the doubling result
// S_BIT_ADD  | conditional add of B for bit k[idx]
// S_ADD_REQ  | one-cycle addition request to the EC unit (P = R, Q = B)
// S_ADD_WAIT | waiting for the addition result
// S_NEXT     | advance to the next lower scalar bit, or finish
// S_DONE     | one-cycle result strobe
module ec_scalar_mul_ctrl #(
  parameter int K_W         = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [5:0]     in_Px,
  input  logic [5:0]     in_Py,
  input  logic [K_W-1:0] in_k,
  input  logic [5:0]     in_prime,
  input  logic [5:0]     in_a,
  output logic           out_valid,
  output logic [5:0]     out_Rx,
  output logic [5:0]     out_Ry,
  output logic           out_inf,
`ifdef ECSM_TIMEOUT_EN
  output logic           out_err,
`endif
  output logic           ec_in_valid,
  output logic [5:0]     ec_Px,
  output logic [5:0]     ec_Py,
  output logic [5:0]     ec_Qx,
  output logic [5:0]     ec_Qy,
  output logic [5:0]     ec_prime,
  output logic [5:0]     ec_a,
  input  logic           ec_out_valid,
  input  logic [5:0]     ec_Rx,
  input  logic [5:0]     ec_Ry
);

  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_BIT_ADD,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state, state_nxt;

  logic [5:0]     bx, by, p_r, a_r;
  logic [K_W-1:0] k_r;

  logic [5:0]     rx, ry, rx_nxt, ry_nxt;
  logic           rinf, rinf_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  // set when a double was issued from BIT_ADD (R == B), so its result
  // finishes the bit instead of going on to the add step
  logic           dbl_tail, dbl_tail_nxt;

  logic           accept;
  logic           cur_bit;
  logic           tmo_hit;
  logic           abort;

  assign accept  = (state == S_IDLE) && in_valid;
  assign cur_bit = k_r[idx];

`ifdef ECSM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  logic          waiting;

  assign waiting = (state == S_DBL_WAIT) || (state == S_ADD_WAIT);

  // Watchdog: reload on every EC request, count down while waiting. Expiry
  // lands the FSM in DONE exactly TIMEOUT_CYC cycles after ec_in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == S_DBL_REQ) || (state == S_ADD_REQ)) begin
      tmo_cnt <= TW'(TIMEOUT_CYC - 1);
    end else if (waiting && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end

  assign tmo_hit = waiting && !ec_out_valid && (tmo_cnt == TW'(1));

  // Abort flag: cleared by each new request, set when the watchdog expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign abort = err_q;
`else
  assign tmo_hit = 1'b0;
  assign abort   = 1'b0;
`endif

  // Operand capture: request inputs are only sampled while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx  <= '0;
      by  <= '0;
      p_r <= '0;
      a_r <= '0;
      k_r <= '0;
    end else if (accept) begin
      bx  <= in_Px;
      by  <= in_Py;
      p_r <= in_prime;
      a_r <= in_a;
      k_r <= in_k;
    end
  end

  // State register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rx       <= '0;
      ry       <= '0;
      rinf     <= 1'b0;
      idx      <= '0;
      dbl_tail <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx       <= rx_nxt;
      ry       <= ry_nxt;
      rinf     <= rinf_nxt;
      idx      <= idx_nxt;
      dbl_tail <= dbl_tail_nxt;
    end
  end

  // Next-state, accumulator update and all outputs (zero unless asserted).
  always_comb begin
    state_nxt    = state;
    rx_nxt       = rx;
    ry_nxt       = ry;
    rinf_nxt     = rinf;
    idx_nxt      = idx;
    dbl_tail_nxt = dbl_tail;

    out_valid    = 1'b0;
    out_Rx       = '0;
    out_Ry       = '0;
    out_inf      = 1'b0;
`ifdef ECSM_TIMEOUT_EN
    out_err      = 1'b0;
`endif
    ec_in_valid  = 1'b0;
    ec_Px        = '0;
    ec_Py        = '0;
    ec_Qx        = '0;
    ec_Qy        = '0;
    ec_prime     = '0;
    ec_a         = '0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt    = S_SCAN;
          rinf_nxt     = 1'b1;
          rx_nxt       = '0;
          ry_nxt       = '0;
          idx_nxt      = IW'(K_W - 1);
          dbl_tail_nxt = 1'b0;
        end
      end

      S_SCAN: begin
        dbl_tail_nxt = 1'b0;
        if (rinf) begin
          state_nxt = S_BIT_ADD;
        end else if (ry == '0) begin
          // 2R = O for a point of order 2; the EC unit cannot do this
          rinf_nxt  = 1'b1;
          state_nxt = S_BIT_ADD;
        end else begin
          state_nxt = S_DBL_REQ;
        end
      end

      S_DBL_REQ: begin
        ec_in_valid = 1'b1;
        ec_Px       = rx;
        ec_Py       = ry;
        ec_Qx       = rx;
        ec_Qy       = ry;
        ec_prime    = p_r;
        ec_a        = a_r;
        state_nxt   = S_DBL_WAIT;
      end

      S_DBL_WAIT: begin
        if (ec_out_valid) begin
          rx_nxt    = ec_Rx;
          ry_nxt    = ec_Ry;
          state_nxt = dbl_tail ? S_NEXT : S_BIT_ADD;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
        end
      end

      S_BIT_ADD: begin
        if (!cur_bit) begin
          state_nxt = S_NEXT;
        end else if (rinf) begin
          // O + B = B
          rx_nxt    = bx;
          ry_nxt    = by;
          rinf_nxt  = 1'b0;
          state_nxt = S_NEXT;
        end else if (rx == bx) begin
          if (ry != by) begin
            // R = -B, sum is the point at infinity
            rinf_nxt  = 1'b1;
            state_nxt = S_NEXT;
          end else if (ry == '0) begin
            rinf_nxt  = 1'b1;
            state_nxt = S_NEXT;
          end else begin
            // R = B: the add degenerates into a double
            dbl_tail_nxt = 1'b1;
            state_nxt    = S_DBL_REQ;
          end
        end else begin
          state_nxt = S_ADD_REQ;
        end
      end

      S_ADD_REQ: begin
        ec_in_valid = 1'b1;
        ec_Px       = rx;
        ec_Py       = ry;
        ec_Qx       = bx;
        ec_Qy       = by;
        ec_prime    = p_r;
        ec_a        = a_r;
        state_nxt   = S_ADD_WAIT;
      end

      S_ADD_WAIT: begin
        if (ec_out_valid) begin
          rx_nxt    = ec_Rx;
          ry_nxt    = ec_Ry;
          state_nxt = S_NEXT;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
        end
      end

      S_NEXT: begin
        if (idx == '0) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx - IW'(1);
          state_nxt = S_SCAN;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        out_inf   = rinf && !abort;
        if (!rinf && !abort) begin
          out_Rx = rx;
          out_Ry = ry;
        end
`ifdef ECSM_TIMEOUT_EN
        out_err   = abort;
`endif
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Bench for ec_scalar_mul_ctrl: directed scalars on y^2 = x^3 + 2x + 2 mod 17
// with P = (5,1) (order 19), plus a y = 0 point on y^2 = x^3 + x mod 5.
// A behavioural EC unit answers with random 1..20 cycle latency; a scoreboard
// queue holds expected results and a monitor checks them on out_valid.
module tb_ec_scalar_mul_ctrl;

  localparam int K_W         = 6;
  localparam int TIMEOUT_CYC = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [5:0]     in_Px = '0;
  logic [5:0]     in_Py = '0;
  logic [K_W-1:0] in_k = '0;
  logic [5:0]     in_prime = '0;
  logic [5:0]     in_a = '0;
  logic           out_valid;
  logic [5:0]     out_Rx;
  logic [5:0]     out_Ry;
  logic           out_inf;
`ifdef ECSM_TIMEOUT_EN
  logic           out_err;
`endif
  logic           ec_in_valid;
  logic [5:0]     ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a;
  logic           ec_out_valid;
  logic [5:0]     ec_Rx, ec_Ry;

  ec_scalar_mul_ctrl #(.K_W(K_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_Px(in_Px),
    .in_Py(in_Py),
    .in_k(in_k),
    .in_prime(in_prime),
    .in_a(in_a),
    .out_valid(out_valid),
    .out_Rx(out_Rx),
    .out_Ry(out_Ry),
    .out_inf(out_inf),
`ifdef ECSM_TIMEOUT_EN
    .out_err(out_err),
`endif
    .ec_in_valid(ec_in_valid),
    .ec_Px(ec_Px),
    .ec_Py(ec_Py),
    .ec_Qx(ec_Qx),
    .ec_Qy(ec_Qy),
    .ec_prime(ec_prime),
    .ec_a(ec_a),
    .ec_out_valid(ec_out_valid),
    .ec_Rx(ec_Rx),
    .ec_Ry(ec_Ry)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seen  = 0;
  int cyc   = 0;
  int req_cyc = 0;
  int out_cyc = 0;
  bit no_resp = 1'b0;
  logic [35:0] req_log[$];

  typedef struct {
    string       name;
    logic        inf;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        err;
    int          nreq;
    int          nchk;
    logic [35:0] op0;
    logic [35:0] op1;
  } exp_t;

  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int md(input int v, input int p);
    int r;
    r = v % p;
    if (r < 0) r += p;
    return r;
  endfunction

  function automatic int inv(input int v, input int p);
    for (int i = 1; i < p; i++) begin
      if (md(v * i, p) == 1) return i;
    end
    return 0;
  endfunction

  function automatic logic [35:0] opk(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5)};
  endfunction

  // Behavioural EC unit: logs each request, answers after 1..20 cycles.
  initial begin
    int px, py, qx, qy, pp, aa, lam, x3, y3, lat;
    bit pend;
    logic [5:0] rx_h, ry_h;
    pend = 1'b0;
    lat  = 0;
    rx_h = '0;
    ry_h = '0;
    ec_out_valid = 1'b0;
    ec_Rx = '0;
    ec_Ry = '0;
    forever begin
      @(negedge clk);
      ec_out_valid = 1'b0;
      if (pend) begin
        lat--;
        if (lat == 0) begin
          ec_out_valid = 1'b1;
          ec_Rx = rx_h;
          ec_Ry = ry_h;
          pend  = 1'b0;
        end
      end
      if (ec_in_valid) begin
        req_log.push_back({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a});
        req_cyc = cyc;
        if (!no_resp) begin
          px = int'(ec_Px); py = int'(ec_Py);
          qx = int'(ec_Qx); qy = int'(ec_Qy);
          pp = int'(ec_prime); aa = int'(ec_a);
          if (px == qx && py == qy)
            lam = md((3 * px * px + aa) * inv(md(2 * py, pp), pp), pp);
          else
            lam = md((qy - py) * inv(md(qx - px, pp), pp), pp);
          x3 = md(lam * lam - px - qx, pp);
          y3 = md(lam * (px - x3) - py, pp);
          rx_h = 6'(x3);
          ry_h = 6'(y3);
          pend = 1'b1;
          lat  = int'($urandom_range(1, 20));
        end
      end
    end
  end

  // Result monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        seen++;
        out_cyc = cyc;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got out_valid=1 expected no result");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_inf"}, longint'(out_inf), longint'(e.inf));
          chk({e.name, "_rx"}, longint'(out_Rx), longint'(e.x));
          chk({e.name, "_ry"}, longint'(out_Ry), longint'(e.y));
`ifdef ECSM_TIMEOUT_EN
          chk({e.name, "_err"}, longint'(out_err), longint'(e.err));
`endif
          chk({e.name, "_nreq"}, longint'(req_log.size()), longint'(e.nreq));
          if (e.nchk > 0 && req_log.size() > 0)
            chk({e.name, "_op0"}, longint'(req_log[0]), longint'(e.op0));
          if (e.nchk > 1 && req_log.size() > 1)
            chk({e.name, "_op1"}, longint'(req_log[1]), longint'(e.op1));
        end
      end
    end
  end

  // Operands must read 0 in every cycle without a request.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !ec_in_valid)
        chk("ec_ops_idle", longint'({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a}), 0);
    end
  end

  task automatic run(input string nm, input int k, input int px, input int py,
                     input int pr, input int a, input logic inf, input int x,
                     input int y, input logic err, input int nreq, input int nchk,
                     input logic [35:0] op0, input logic [35:0] op1, input bit poke);
    exp_t e;
    int s;
    @(negedge clk);
    req_log.delete();
    e.name = nm; e.inf = inf; e.x = 6'(x); e.y = 6'(y); e.err = err;
    e.nreq = nreq; e.nchk = nchk; e.op0 = op0; e.op1 = op1;
    sbq.push_back(e);
    s = seen;
    in_Px = 6'(px); in_Py = 6'(py); in_prime = 6'(pr); in_a = 6'(a);
    in_k = K_W'(k);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && seen == s; c++) begin
      @(negedge clk);
      // a request strobe while busy must be ignored
      in_valid = poke && (c == 10);
      if (in_valid) begin
        in_k = '0; in_Px = 6'd3; in_Py = 6'd1;
      end
    end
    in_valid = 1'b0;
    chk({nm, "_complete"}, longint'(seen - s), 1);
    if (seen == s) sbq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_rx", longint'(out_Rx), 0);
    chk("rst_out_ry", longint'(out_Ry), 0);
    chk("rst_out_inf", longint'(out_inf), 0);
    chk("rst_ec_in_valid", longint'(ec_in_valid), 0);
    chk("rst_ec_ops", longint'({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a}), 0);
`ifdef ECSM_TIMEOUT_EN
    chk("rst_out_err", longint'(out_err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("k0",  0, 5, 1, 17, 2, 1'b1, 0, 0, 1'b0, 0, 0, '0, '0, 1'b0);
    run("k1",  1, 5, 1, 17, 2, 1'b0, 5, 1, 1'b0, 0, 0, '0, '0, 1'b0);
    run("k2",  2, 5, 1, 17, 2, 1'b0, 6, 3, 1'b0, 1, 1,
        opk(5, 1, 5, 1, 17, 2), '0, 1'b0);
    run("k3",  3, 5, 1, 17, 2, 1'b0, 10, 6, 1'b0, 2, 2,
        opk(5, 1, 5, 1, 17, 2), opk(6, 3, 5, 1, 17, 2), 1'b0);
    run("k19", 19, 5, 1, 17, 2, 1'b1, 0, 0, 1'b0, 5, 0, '0, '0, 1'b0);
    run("k21", 21, 5, 1, 17, 2, 1'b0, 6, 3, 1'b0, 6, 0, '0, '0, 1'b0);
    run("k38", 38, 5, 1, 17, 2, 1'b1, 0, 0, 1'b0, 5, 0, '0, '0, 1'b0);
    run("k63", 63, 5, 1, 17, 2, 1'b0, 16, 13, 1'b0, 10, 0, '0, '0, 1'b1);
    run("y0_k2", 2, 0, 0, 5, 1, 1'b1, 0, 0, 1'b0, 0, 0, '0, '0, 1'b0);
    run("y0_k3", 3, 0, 0, 5, 1, 1'b0, 0, 0, 1'b0, 0, 0, '0, '0, 1'b0);

    // abort a k = 19 run with reset, then repeat it
    @(negedge clk);
    in_Px = 6'd5; in_Py = 6'd1; in_prime = 6'd17; in_a = 6'd2; in_k = K_W'(19);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_ec_in_valid", longint'(ec_in_valid), 0);
    chk("midrst_ec_ops", longint'({ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", longint'({out_valid, ec_in_valid}), 0);
    end
    run("k19_rerun", 19, 5, 1, 17, 2, 1'b1, 0, 0, 1'b0, 5, 0, '0, '0, 1'b0);

`ifdef ECSM_TIMEOUT_EN
    no_resp = 1'b1;
    run("tmo_k2", 2, 5, 1, 17, 2, 1'b0, 0, 0, 1'b1, 1, 1,
        opk(5, 1, 5, 1, 17, 2), '0, 1'b0);
    chk("tmo_latency", longint'(out_cyc - req_cyc), TIMEOUT_CYC);
    no_resp = 1'b0;
    run("tmo_after_k3", 3, 5, 1, 17, 2, 1'b0, 10, 6, 1'b0, 2, 2,
        opk(5, 1, 5, 1, 17, 2), opk(6, 3, 5, 1, 17, 2), 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ec_scalar_mul_ctrl.md
# ec_scalar_mul_ctrl

Sequencer that computes the scalar multiple k·P on a short-Weierstrass curve y² = x³ + a·x + b over GF(p), p ≤ 61, by driving the existing single-operation EC point-add/double unit through its in_valid/out_valid handshake. It runs left-to-right double-and-add over the 6-bit scalar. It handles every case the EC unit cannot: the point at infinity, P + (−P), and doubling a point with y = 0. It sits between the top-level request port and one EC unit instance and owns that unit exclusively.

## Interface
- K_W, 6, scalar width in bits
- TIMEOUT_CYC, 1000, watchdog limit in cycles per EC request (used only under ECSM_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle request strobe
- in_Px, in_Py  in  6  base point P (affine, on curve, < in_prime)
- in_k  in  K_W  scalar
- in_prime, in_a  in  6  field prime, curve coefficient a
- out_valid  out  1  one-cycle result strobe
- out_Rx, out_Ry  out  6  result coordinates; 0 when out_inf = 1
- out_inf  out  1  result is the point at infinity
- out_err  out  1  watchdog abort (present only with ECSM_TIMEOUT_EN)
- ec_in_valid  out  1  request strobe to EC unit
- ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a  out  6  EC unit operands
- ec_out_valid  in  1  EC unit result strobe
- ec_Rx, ec_Ry  in  6  EC unit result

## Operation
- Registers: base point (Bx, By), k, p, a, accumulator (Rx, Ry, Rinf), bit index idx.
- IDLE: on in_valid, latch inputs; set Rinf = 1, idx = K_W−1; go to SCAN. in_valid is ignored in any other state.
- SCAN (bit k[idx]):
  - If Rinf = 1, skip the double.
  - Else if Ry = 0, set Rinf = 1 without an EC request.
  - Else go to DBL_REQ.
  - After the double completes (or is skipped), go to BIT_ADD.
- BIT_ADD: if k[idx] = 0, go to NEXT. If k[idx] = 1:
  - Rinf = 1: copy B into R, clear Rinf, no EC request.
  - Rx = Bx and Ry = By: issue a doubling of R through DBL_REQ, with the same Ry = 0 rule.
  - Rx = Bx and Ry ≠ By: set Rinf = 1, no EC request.
  - Otherwise go to ADD_REQ (P = R, Q = B).
- DBL_REQ / ADD_REQ: drive ec_in_valid = 1 for exactly one cycle. Operands are valid in that cycle only and 0 in all other cycles. A double uses P = Q = R. Then go to the matching WAIT state.
- DBL_WAIT / ADD_WAIT: on ec_out_valid, load R = (ec_Rx, ec_Ry) and continue.
- NEXT: if idx = 0, go to DONE; else decrement idx and go to SCAN.
- DONE: out_valid = 1 for one cycle, with out_Rx/out_Ry = R (0 if Rinf) and out_inf = Rinf; then return to IDLE.
- k = 0 produces infinity with no EC requests.
- ec_out_valid outside a WAIT state is ignored.

## Timing
- Reset (async, rst_n low): state IDLE. All outputs are 0: out_valid, out_Rx, out_Ry, out_inf, out_err, ec_in_valid, all ec_* operands.
- Reset asserted mid-operation aborts immediately. Any later ec_out_valid from the aborted request is ignored in IDLE.
- The request is sampled on the rising edge where in_valid = 1. ec_in_valid asserts no earlier than the following cycle.
- Non-EC steps (SCAN, BIT_ADD, NEXT, copy, infinity rules) take 1 cycle each.
- Latency = 2 + Σ(per bit: SCAN + BIT_ADD + NEXT) + Σ(EC unit latency + 1 per request).
- After ec_out_valid, ec_in_valid is not reasserted until at least one cycle later.
- out_valid never coincides with in_valid acceptance. The next request is accepted one cycle after out_valid.

## Configuration
- ECSM_TIMEOUT_EN defined:
  - A counter starts at each ec_in_valid. If no ec_out_valid arrives within TIMEOUT_CYC cycles, the block aborts.
  - Abort behaviour: DONE with out_valid = 1, out_err = 1, out_Rx = out_Ry = 0, out_inf = 0.
  - out_err is 0 on every normal result.
- Not defined: no counter and no out_err port. A WAIT state waits indefinitely.

## Test plan
Curve p = 17, a = 2, P = (5,1), group order 19. The EC unit is a behavioural model with random latency of 1–20 cycles.
- k = 0 -> out_inf = 1, Rx = Ry = 0; zero ec_in_valid pulses.
- k = 1 -> (5,1), out_inf = 0; zero EC requests.
- k = 2 -> (6,3); exactly one doubling request, with operands (5,1,5,1,17,2).
- k = 3 -> (10,6); one double, then one add with P = (6,3), Q = (5,1).
- k = 19 -> the final step meets R = 18P = (5,16) against B = (5,1); out_inf = 1 with no EC request issued for that step. Apply reset mid-run on the next k = 19 request, then rerun; the result must be identical.
- ECSM_TIMEOUT_EN with an EC model that never responds, k = 2 -> out_valid with out_err = 1 exactly TIMEOUT_CYC cycles after ec_in_valid; the next request completes normally.
